// File: rtl/vga_pkg.sv
// Shared VGA geometry, rect-controller state type and clamp helper.
package vga_pkg;
  localparam int unsigned HOR_PIXELS = 1024;
  localparam int unsigned VER_PIXELS = 768;
  localparam int unsigned POS_W      = 12;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {IDLE, PENDING} rect_ctl_state_t;

  function automatic pos_t clamp_pos(input pos_t v, input pos_t lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/rect_pos_ctl_if.sv
// Position request channel from game logic: valid/ready with (x, y, show) payload.
interface rect_pos_ctl_if;
  import vga_pkg::*;

  logic req_valid;
  logic req_ready;
  pos_t req_x;
  pos_t req_y;
  logic req_show;

  modport master (output req_valid, req_x, req_y, req_show, input req_ready);
  modport slave  (input req_valid, req_x, req_y, req_show, output req_ready);
endinterface

// File: rtl/blink_timer.sv
// Frame counter toggling a blink phase every BLINK_FRAMES ticks; clear restarts visible.
// Updates on the clock edge after tick/clear; clear has priority over tick.
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output logic phase
);
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/rect_pos_ctl.sv
// Tear-free draw_rect position controller: requests are clamped, shadowed and committed at vblank start.
// Commit visible 1 clk after vblank rise (enable 1 clk later); req_ready low while a request is pending.
module rect_pos_ctl
  import vga_pkg::*;
#(
  parameter int unsigned SCREEN_W     = HOR_PIXELS,
  parameter int unsigned SCREEN_H     = VER_PIXELS,
  parameter int unsigned RECT_WIDTH   = 48,
  parameter int unsigned RECT_HEIGHT  = 64,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vblnk,
  rect_pos_ctl_if.slave        req,
  input  logic                 blink_en,
  output pos_t                 x_pos,
  output pos_t                 y_pos,
  output logic                 enable,
  output logic                 pending
);
  localparam pos_t X_MAX = pos_t'(SCREEN_W - RECT_WIDTH);
  localparam pos_t Y_MAX = pos_t'(SCREEN_H - RECT_HEIGHT);

  rect_ctl_state_t state, state_nxt;

  logic vb_d;
  logic vb_rise;
  logic accept;
  logic commit;
  logic show_r;
  logic phase;
  pos_t shadow_x;
  pos_t shadow_y;
  logic shadow_show;

  // vb_d resets high so leaving reset inside vblank is not seen as a frame start
  always_ff @(posedge clk) begin
    if (rst) vb_d <= 1'b1;
    else     vb_d <= vblnk;
  end

  assign vb_rise = vblnk & ~vb_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req.req_ready = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        req.req_ready = ~rst;
        accept        = req.req_valid & ~rst;
        if (accept) state_nxt = PENDING;
      end
      PENDING: begin
        commit = vb_rise;
        if (vb_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x    <= '0;
      shadow_y    <= '0;
      shadow_show <= 1'b0;
    end else if (accept) begin
      shadow_x    <= clamp_pos(req.req_x, X_MAX);
      shadow_y    <= clamp_pos(req.req_y, Y_MAX);
      shadow_show <= req.req_show;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos  <= '0;
      y_pos  <= '0;
      show_r <= 1'b0;
    end else if (commit) begin
      x_pos  <= shadow_x;
      y_pos  <= shadow_y;
      show_r <= shadow_show;
    end
  end

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .tick  (vb_rise),
    .clear (commit),
    .phase (phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enable  <= 1'b0;
      pending <= 1'b0;
    end else begin
      enable  <= show_r & (~blink_en | phase);
      pending <= (state_nxt == PENDING);
    end
  end
endmodule

// File: tb/tb_rect_pos_ctl.sv
// Directed plus randomized bench for rect_pos_ctl against a frame-level reference model.
module tb_rect_pos_ctl;
  import vga_pkg::*;

  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst;
  logic vblnk;
  logic blink_en;
  pos_t x_pos;
  pos_t y_pos;
  logic enable;
  logic pending;

  rect_pos_ctl_if rif ();

  rect_pos_ctl #(.BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .req      (rif.slave),
    .blink_en (blink_en),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .enable   (enable),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: committed state, one pending request, frames since last commit/reset
  int m_x, m_y, m_px, m_py, m_frames;
  bit m_show, m_pshow, m_pend;

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic m_en();
    bit ph;
    ph = ((m_frames / BF) % 2) == 0;
    return m_show && (!blink_en || ph);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, "_x"},     32'(x_pos),        32'(m_x));
    chk({tag, "_y"},     32'(y_pos),        32'(m_y));
    chk({tag, "_en"},    32'(enable),       32'(m_en()));
    chk({tag, "_pend"},  32'(pending),      32'(m_pend));
    chk({tag, "_ready"}, 32'(rif.req_ready), 32'(!m_pend));
  endtask

  task automatic accept_model(input int x, input int y, input bit s);
    m_pend  = 1'b1;
    m_px    = clampv(x, HOR_PIXELS - 48);
    m_py    = clampv(y, VER_PIXELS - 64);
    m_pshow = s;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    rif.req_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(rif.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    m_x = 0; m_y = 0; m_show = 0; m_pend = 0; m_frames = 0;
    tick();
  endtask

  task automatic request(input int x, input int y, input bit s);
    tick();
    rif.req_valid = 1'b1;
    rif.req_x     = pos_t'(x);
    rif.req_y     = pos_t'(y);
    rif.req_show  = s;
    @(negedge clk);
    chk("req_ready", 32'(rif.req_ready), 32'(!m_pend));
    tick();
    rif.req_valid = 1'b0;
    if (!m_pend) accept_model(x, y, s);
  endtask

  task automatic vblank(input bit req_on_rise, input int rx, input int ry, input bit rs);
    logic en_old;
    bit   was_ready;
    tick();
    en_old = m_en();
    vblnk = 1'b1;
    if (req_on_rise) begin
      rif.req_valid = 1'b1;
      rif.req_x     = pos_t'(rx);
      rif.req_y     = pos_t'(ry);
      rif.req_show  = rs;
    end
    @(negedge clk);
    chk("pre_x", 32'(x_pos), 32'(m_x));
    if (req_on_rise) chk("rise_ready", 32'(rif.req_ready), 32'(!m_pend));
    was_ready = !m_pend;
    if (m_pend) begin
      m_x = m_px; m_y = m_py; m_show = m_pshow; m_pend = 0; m_frames = 0;
    end else begin
      m_frames++;
    end
    if (req_on_rise && was_ready) accept_model(rx, ry, rs);
    tick();
    rif.req_valid = 1'b0;
    @(negedge clk);
    chk("vb_x",       32'(x_pos),   32'(m_x));
    chk("vb_y",       32'(y_pos),   32'(m_y));
    chk("vb_en_hold", 32'(enable),  32'(en_old));
    chk("vb_pend",    32'(pending), 32'(m_pend));
    tick();
    @(negedge clk);
    chk("vb_en", 32'(enable), 32'(m_en()));
    tick();
    vblnk = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit pat [6] = '{1, 1, 0, 0, 1, 1};
    rst = 1'b1; vblnk = 1'b0; blink_en = 1'b0;
    rif.req_valid = 1'b0; rif.req_x = '0; rif.req_y = '0; rif.req_show = 1'b0;

    // Reset and idle frame
    do_reset();
    check_all("reset");
    vblank(0, 0, 0, 0);
    check_all("idle");

    // Mid-frame request held until vblank, then committed
    request(100, 200, 1);
    check_all("t2_pend");
    vblank(0, 0, 0, 0);
    chk("t2_x", 32'(x_pos), 32'd100);
    chk("t2_y", 32'(y_pos), 32'd200);
    check_all("t2_done");

    // Clamping at the screen edge
    request(1020, 760, 1);
    vblank(0, 0, 0, 0);
    chk("t3_x", 32'(x_pos), 32'd976);
    chk("t3_y", 32'(y_pos), 32'd704);

    // Backpressure while pending; request on the vb_rise cycle waits a frame
    request(10, 20, 1);
    request(300, 400, 0);
    vblank(0, 0, 0, 0);
    chk("t4_first", 32'(x_pos), 32'd10);
    vblank(1, 50, 60, 1);
    chk("t4_rise_hold", 32'(x_pos), 32'd10);
    chk("t4_rise_pend", 32'(pending), 32'd1);
    vblank(0, 0, 0, 0);
    chk("t4_rise_commit", 32'(x_pos), 32'd50);

    // Blink pattern 1,1,0,0,1,1 from commit, restarted by a new commit
    blink_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t5_f0", 32'(enable), 32'(pat[0]));
    for (int f = 1; f < 6; f++) begin
      vblank(0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("t5_f%0d", f), 32'(enable), 32'(pat[f]));
    end
    vblank(0, 0, 0, 0);
    request(5, 5, 1);
    vblank(0, 0, 0, 0);
    for (int f = 1; f < 4; f++) begin
      @(negedge clk);
      chk($sformatf("t5_restart%0d", f), 32'(enable), 32'(pat[f-1]));
      vblank(0, 0, 0, 0);
    end

    // Reset while pending discards the request
    blink_en = 1'b0;
    request(700, 300, 1);
    do_reset();
    vblank(0, 0, 0, 0);
    chk("t6_x",  32'(x_pos),   32'd0);
    chk("t6_en", 32'(enable),  32'd0);
    chk("t6_pd", 32'(pending), 32'd0);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      blink_en = 1'($urandom);
      tick(); tick();
      check_all("rnd_a");
      if ($urandom_range(0, 1) == 1)
        request($urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom));
      if ($urandom_range(0, 2) == 0)
        request($urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom));
      check_all("rnd_b");
      if ($urandom_range(0, 15) == 0) do_reset();
      vblank($urandom_range(0, 3) == 0, $urandom_range(0, 4095), $urandom_range(0, 4095),
             1'($urandom));
      check_all("rnd_c");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
